// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl
//   Sequencer between the multicycle control unit and the iterative divider.
//   It accepts a one-cycle divide request and registers the operands. It
//   pulses the divider start, waits for done or divide-by-zero (with a
//   timeout), and commits remainder/quotient into the architectural HI/LO
//   registers. It also services MTHI/MTLO writes. HI/LO are always readable.
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   div_req_i        one-cycle start request (ignored while busy)
//   op_a_i/op_b_i    dividend / divisor, sampled on accept
//   hi_write_i       MTHI strobe, data on hi_in_i
//   lo_write_i       MTLO strobe, data on lo_in_i
//   div_stop_i       divider done level
//   div_zero_i       divider divide-by-zero flag
//   hi_div_i         divider remainder
//   lo_div_i         divider quotient
//   div_control_o    start pulse to the divider
//   div_a_o/div_b_o  registered operands, stable for the whole operation
//   div_busy_o       high in every state except idle
//   div_done_o       one-cycle pulse, HI/LO committed
//   div_zero_exc_o   one-cycle pulse, divide by zero, HI/LO untouched
//   div_timeout_o    one-cycle pulse, divider never finished, HI/LO untouched
//   hi_out_o/lo_out_o architectural HI / LO
module div_hilo_ctrl #(
    parameter int unsigned Timeout = 48,
    parameter int unsigned Cw      = 6
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        div_req_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        hi_write_i,
    input  logic        lo_write_i,
    input  logic [31:0] hi_in_i,
    input  logic [31:0] lo_in_i,
    input  logic        div_stop_i,
    input  logic        div_zero_i,
    input  logic [31:0] hi_div_i,
    input  logic [31:0] lo_div_i,
    output logic        div_control_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    output logic        div_busy_o,
    output logic        div_done_o,
    output logic        div_zero_exc_o,
    output logic        div_timeout_o,
    output logic [31:0] hi_out_o,
    output logic [31:0] lo_out_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StSettle,
        StWait,
        StCommit,
        StZexc,
        StTout
    } state_e;

    // Last wait-counter value before the operation is abandoned.
    localparam logic [Cw-1:0] CntLast = Cw'(Timeout - 1);

    state_e         state_q, state_d;
    logic [Cw-1:0]  cnt_q, cnt_d;
    logic [31:0]    div_a_q, div_a_d;
    logic [31:0]    div_b_q, div_b_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_a_q <= '0;
            div_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_a_q <= div_a_d;
            div_b_q <= div_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state logic for the sequencer and operand/counter registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_a_d = div_a_q;
        div_b_d = div_b_q;

        unique case (state_q)
            StIdle: begin
                if (div_req_i) begin
                    div_a_d = op_a_i;
                    div_b_d = op_b_i;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StSettle;
            end
            StSettle: begin
                // div_stop_i may still be high from the previous operation.
                // Ignore it until the divider has seen the start pulse.
                state_d = div_zero_i ? StZexc : StWait;
            end
            StWait: begin
                cnt_d = cnt_q + Cw'(1);
                if (div_stop_i) begin
                    state_d = StCommit;
                end else if (cnt_q == CntLast) begin
                    state_d = StTout;
                end
            end
            StCommit: state_d = StIdle;
            StZexc:   state_d = StIdle;
            StTout:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // HI/LO update. A divider commit takes priority over MTHI/MTLO in the
    // same cycle.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_write_i) begin
            hi_d = hi_in_i;
        end
        if (lo_write_i) begin
            lo_d = lo_in_i;
        end
        if (state_q == StCommit) begin
            hi_d = hi_div_i;
            lo_d = lo_div_i;
        end
    end

    // Status outputs decode the state register directly, so an asynchronous
    // reset drops them at once.
    always_comb begin
        div_control_o  = 1'b0;
        div_done_o     = 1'b0;
        div_zero_exc_o = 1'b0;
        div_timeout_o  = 1'b0;
        div_busy_o     = (state_q != StIdle);
        unique case (state_q)
            StLaunch: div_control_o  = 1'b1;
            StCommit: div_done_o     = 1'b1;
            StZexc:   div_zero_exc_o = 1'b1;
            StTout:   div_timeout_o  = 1'b1;
            default:  ;
        endcase
    end

    assign div_a_o  = div_a_q;
    assign div_b_o  = div_b_q;
    assign hi_out_o = hi_q;
    assign lo_out_o = lo_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb_div_hilo_ctrl
//   Bench for div_hilo_ctrl. It uses a behavioural divider stub that takes 32
//   cycles and can be made to hang. Every operation pushes its expected
//   outcome to a scoreboard queue. The entry is popped and compared when
//   the sequencer emits its completion pulse.
module tb_div_hilo_ctrl;

    localparam int KDone = 0;
    localparam int KZexc = 1;
    localparam int KTout = 2;
    localparam int NoInject = -1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_req = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        hi_write = 1'b0;
    logic        lo_write = 1'b0;
    logic [31:0] hi_in = '0;
    logic [31:0] lo_in = '0;
    logic        div_stop;
    logic        div_zero;
    logic [31:0] hi_div;
    logic [31:0] lo_div;
    logic        div_control;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_busy;
    logic        div_done;
    logic        div_zero_exc;
    logic        div_timeout;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          kind;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [31:0] hi_model = '0;
    logic [31:0] lo_model = '0;

    int ctrl_cnt = 0;
    int done_cnt = 0;
    int zexc_cnt = 0;
    int tout_cnt = 0;

    always #5 clk = ~clk;

    div_hilo_ctrl #(
        .Timeout(48),
        .Cw     (6)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .div_req_i     (div_req),
        .op_a_i        (op_a),
        .op_b_i        (op_b),
        .hi_write_i    (hi_write),
        .lo_write_i    (lo_write),
        .hi_in_i       (hi_in),
        .lo_in_i       (lo_in),
        .div_stop_i    (div_stop),
        .div_zero_i    (div_zero),
        .hi_div_i      (hi_div),
        .lo_div_i      (lo_div),
        .div_control_o (div_control),
        .div_a_o       (div_a),
        .div_b_o       (div_b),
        .div_busy_o    (div_busy),
        .div_done_o    (div_done),
        .div_zero_exc_o(div_zero_exc),
        .div_timeout_o (div_timeout),
        .hi_out_o      (hi_out),
        .lo_out_o      (lo_out)
    );

    // Divider stub. divStop stays stale for one cycle after the start pulse.
    // The stub then counts 32 iterations. With stub_hang set it never
    // finishes.
    logic stub_hang = 1'b0;
    logic clr_pend;
    int   stub_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_stop <= 1'b0;
            div_zero <= 1'b0;
            hi_div   <= '0;
            lo_div   <= '0;
            clr_pend <= 1'b0;
            stub_cnt <= 0;
        end else if (div_control) begin
            clr_pend <= 1'b1;
            div_zero <= (div_b == 32'd0);
            stub_cnt <= (div_b == 32'd0 || stub_hang) ? 0 : 32;
        end else begin
            if (clr_pend) begin
                clr_pend <= 1'b0;
                div_stop <= 1'b0;
            end
            if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    div_stop <= 1'b1;
                    lo_div   <= $signed(div_a) / $signed(div_b);
                    hi_div   <= $signed(div_a) % $signed(div_b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            ctrl_cnt += int'(div_control);
            done_cnt += int'(div_done);
            zexc_cnt += int'(div_zero_exc);
            tout_cnt += int'(div_timeout);
        end
    end

    // Issue one divide and check its outcome against the scoreboard.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int kind,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int exp_lat, input int inject_at, input bit mt_hi_on_pulse);
        exp_t e;
        int   c0, p0, lat, got;
        e = '{kind: kind, lo: exp_lo, hi: exp_hi, lat: exp_lat};
        sb.push_back(e);
        c0 = ctrl_cnt;
        p0 = done_cnt + zexc_cnt + tout_cnt;

        @(negedge clk);
        op_a = a;
        op_b = b;
        div_req = 1'b1;
        @(posedge clk);
        #1;
        div_req = 1'b0;
        op_a = ~a;
        op_b = ~b;
        vectors++;
        if (div_control !== 1'b1) begin
            miscompares++;
            $display("FAIL launch_pulse: got %b expected 1", div_control);
        end

        lat = 0;
        got = -1;
        while (got < 0 && lat < 200) begin
            if (lat == inject_at) begin
                div_req = 1'b1;
                op_a = 32'd999;
                op_b = 32'd1;
            end else begin
                div_req = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (div_done) got = KDone;
            else if (div_zero_exc) got = KZexc;
            else if (div_timeout) got = KTout;
        end
        div_req = 1'b0;
        if (mt_hi_on_pulse) begin
            hi_write = 1'b1;
            hi_in = 32'h0000_AAAA;
        end

        e = sb.pop_front();
        vectors++;
        if (got != e.kind) begin
            miscompares++;
            $display("FAIL outcome_kind: got %0d expected %0d", got, e.kind);
        end
        vectors++;
        if (lat != e.lat) begin
            miscompares++;
            $display("FAIL outcome_latency: got %0d expected %0d", lat, e.lat);
        end
        vectors++;
        if (div_a !== a || div_b !== b) begin
            miscompares++;
            $display("FAIL operand_hold: got %h/%h expected %h/%h", div_a, div_b, a, b);
        end

        @(posedge clk);
        #1;
        hi_write = 1'b0;
        vectors++;
        if (hi_out !== e.hi || lo_out !== e.lo) begin
            miscompares++;
            $display("FAIL hilo_result: got hi=%h lo=%h expected hi=%h lo=%h",
                     hi_out, lo_out, e.hi, e.lo);
        end
        vectors++;
        if ({div_busy, div_done, div_zero_exc, div_timeout} !== 4'b0000) begin
            miscompares++;
            $display("FAIL back_to_idle: got %b expected 0000",
                     {div_busy, div_done, div_zero_exc, div_timeout});
        end
        vectors++;
        if (ctrl_cnt - c0 != 1 || done_cnt + zexc_cnt + tout_cnt - p0 != 1) begin
            miscompares++;
            $display("FAIL single_pulses: got ctrl=%0d end=%0d expected 1/1",
                     ctrl_cnt - c0, done_cnt + zexc_cnt + tout_cnt - p0);
        end
        hi_model = e.hi;
        lo_model = e.lo;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({div_control, div_busy, div_done, div_zero_exc, div_timeout} !== 5'b0 ||
            div_a !== 32'd0 || div_b !== 32'd0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: got ctl=%b a=%h b=%h hi=%h lo=%h expected all 0",
                     {div_control, div_busy, div_done, div_zero_exc, div_timeout},
                     div_a, div_b, hi_out, lo_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mt_write();
        @(negedge clk);
        hi_write = 1'b1;
        hi_in = 32'h0000_5678;
        lo_write = 1'b1;
        lo_in = 32'h0000_1234;
        @(posedge clk);
        #1;
        hi_write = 1'b0;
        lo_write = 1'b0;
        vectors++;
        if (hi_out !== 32'h5678 || lo_out !== 32'h1234 || div_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mt_write: got hi=%h lo=%h busy=%b expected 5678/1234/0",
                     hi_out, lo_out, div_busy);
        end
        hi_model = 32'h5678;
        lo_model = 32'h1234;
    endtask

    task automatic test_divide();
        run_op(32'd100, 32'd7, KDone, 32'd14, 32'd2, 34, NoInject, 1'b0);
    endtask

    task automatic test_div_zero();
        run_op(32'd5, 32'd0, KZexc, lo_model, hi_model, 2, NoInject, 1'b0);
    endtask

    task automatic test_signed();
        run_op(32'hFFFF_FFF9, 32'd2, KDone, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, NoInject, 1'b0);
    endtask

    task automatic test_req_while_busy();
        run_op(32'd1000, 32'd10, KDone, 32'd100, 32'd0, 34, 10, 1'b0);
    endtask

    task automatic test_timeout();
        stub_hang = 1'b1;
        run_op(32'd77, 32'd3, KTout, lo_model, hi_model, 50, NoInject, 1'b0);
        stub_hang = 1'b0;
    endtask

    task automatic test_mt_commit_collision();
        run_op(32'd50, 32'd8, KDone, 32'd6, 32'd2, 34, NoInject, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_op(32'd21, 32'd4, KDone, 32'd5, 32'd1, 34, NoInject, 1'b0);
        run_op(32'd9, 32'd3, KDone, 32'd3, 32'd0, 34, NoInject, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        int d0;
        @(negedge clk);
        op_a = 32'd90;
        op_b = 32'd9;
        div_req = 1'b1;
        @(negedge clk);
        div_req = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (div_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_wait: got %b expected 1", div_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({div_control, div_busy, div_done, div_zero_exc, div_timeout} !== 5'b0 ||
            div_a !== 32'd0 || div_b !== 32'd0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_wait: got ctl=%b a=%h b=%h hi=%h lo=%h expected all 0",
                     {div_control, div_busy, div_done, div_zero_exc, div_timeout},
                     div_a, div_b, hi_out, lo_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hi_model = '0;
        lo_model = '0;
        d0 = done_cnt + zexc_cnt + tout_cnt + ctrl_cnt;
        repeat (60) @(negedge clk);
        vectors++;
        if (done_cnt + zexc_cnt + tout_cnt + ctrl_cnt != d0 || div_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_pulse_after_reset: got %0d pulses busy=%b expected 0/0",
                     done_cnt + zexc_cnt + tout_cnt + ctrl_cnt - d0, div_busy);
        end
    endtask

    initial begin
        test_reset();
        test_mt_write();
        test_divide();
        test_div_zero();
        test_signed();
        test_req_while_busy();
        test_timeout();
        test_mt_commit_collision();
        test_back_to_back();
        test_reset_mid_wait();
        test_divide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
